tpu_result_drain: RTL and testbench
===================================

Name: tpu_result_drain

Overview:
Hardware reader for the TOP_tpu result SRAM and the hardware counterpart of the bench-side result checker. On a rising edge of end_ it walks result rows 0..MATRIX_SIZE-1 through the synchronous result-SRAM read port. Each row is streamed out on a valid/ready interface, with a small skid FIFO absorbing backpressure. It sits between TOP_tpu and the host/output DMA.

Parameters:
ADDRESSSIZE, 10, result SRAM address width
MATRIX_SIZE, 32, number of result rows per drain
PARTIAL_SUM_BW, 24, bits per accumulated element
WORDSIZE_Result, MATRIX_SIZE*PARTIAL_SUM_BW, result row width
BASE_ADDR, 0, result SRAM address of row 0
SKID_DEPTH, 2, output buffer entries (min 2)

Ports:
clk  in  1  single clock, all logic on posedge
rstn  in  1  asynchronous, active-low reset
end_  in  1  TOP_tpu completion; rising edge starts a drain
sram_result_re  out  1  read enable to result SRAM
sram_result_address  out  ADDRESSSIZE  read address
sram_result_data_out  in  WORDSIZE_Result  read data, valid 1 cycle after re
out_valid  out  1  out_data holds a row
out_ready  in  1  consumer accepts row when out_valid&&out_ready
out_data  out  WORDSIZE_Result  result row
out_row  out  clog2(MATRIX_SIZE)  row index of out_data
out_last  out  1  high with row MATRIX_SIZE-1
busy  out  1  drain in progress
done  out  1  one-cycle pulse after last handshake
err_overrun  out  1  sticky: end_ edge seen while busy

Behaviour:
- Reset values (async, rstn=0): all outputs 0, sram_result_address=BASE_ADDR, FSM=IDLE, FIFO empty, counters 0, end_d=0.
- Edge detect: end_d registered each cycle; start_evt = end_ && !end_d.
- FSM IDLE -> READ on start_evt. READ -> DRAIN when the last read has been issued. DRAIN -> DONE when the last row handshakes. DONE -> IDLE unconditionally after 1 cycle; done=1 only in DONE.
- busy=1 in READ and DRAIN.
- Reads:
  - rd_cnt 0..MATRIX_SIZE-1; address = BASE_ADDR + rd_cnt, truncated to ADDRESSSIZE.
  - Issue (re=1) in READ only when count + inflight - pop < SKID_DEPTH, where pop = out_valid&&out_ready in the same cycle.
  - rd_cnt increments on issue; inflight = re delayed 1 cycle.
  - Data is pushed into the FIFO with row tag in the cycle after re.
- Latency:
  - start_evt sampled at edge T; first re in cycle T+1; row 0 out_valid in cycle T+3.
  - With out_ready held 1: one row per cycle, last row at T+2+MATRIX_SIZE, done at T+3+MATRIX_SIZE.
- Backpressure:
  - out_data, out_row and out_last stay stable while out_valid&&!out_ready.
  - No row is ever dropped or duplicated; the FIFO never overflows because the credit check forbids it.
- out_last = (out_row == MATRIX_SIZE-1) && out_valid.
- Simultaneous events:
  - Push and pop in the same cycle keep count unchanged.
  - A start_evt in DONE is ignored, not queued.
- start_evt while busy: ignored, err_overrun <= 1.
  - err_overrun is cleared only by reset or by the next accepted start_evt in IDLE (clear and start happen in the same cycle).
- Reset mid-drain: immediate return to IDLE with FIFO flushed; no done pulse.
- end_ held high across drains: no retrigger without a falling edge.

Decomposition:
- Package tpu_drain_pkg: FSM state enum {IDLE, READ, DRAIN, DONE}; ROW_W = clog2(MATRIX_SIZE); CNT_W = clog2(SKID_DEPTH+1).
- Sub-module result_skid_fifo:
  - SKID_DEPTH entries of {row tag, data}.
  - Push/pop ports, count output, first-word-fall-through output.

Test Plan:
- Basic drain: SRAM row i = {MATRIX_SIZE{24'(i+1)}}, out_ready=1, end_ pulse -> rows 0..31 in 32 consecutive cycles starting 3 cycles after the sampled edge; out_last only on row 31; done exactly 1 cycle after it; re high for exactly 32 cycles.
- Backpressure: out_ready toggles 1,0,0,1 repeating -> all 32 rows delivered in order; data stable while stalled; sram_result_re never raised with count+inflight already at 2.
- Overrun: second end_ rising edge at row 10 -> err_overrun=1 and stays 1; drain completes 32 rows; the next end_ after done clears it and starts a new drain.
- Reset mid-drain: rstn low at row 15 -> same-cycle out_valid=0, busy=0, done never pulses; a following end_ drains from row 0.
- Held end_: end_ stays 1 for 100 cycles -> exactly one drain and one done pulse.
- BASE_ADDR=992, MATRIX_SIZE=32 -> addresses 992..1023 with no wrap; out_row still 0..31.

Source files
------------

// File: rtl/tpu_drain_pkg.sv
// Shared types and width helpers for the TPU result-drain block.
package tpu_drain_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} drain_state_e;

    localparam int unsigned MATRIX_SIZE_DEF = 32;
    localparam int unsigned SKID_DEPTH_DEF  = 2;

    // clog2 that never returns 0, so single-entry ranges still get a 1-bit field
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned ROW_W = clog2_min1(MATRIX_SIZE_DEF);
    localparam int unsigned CNT_W = clog2_min1(SKID_DEPTH_DEF + 1);

endpackage

// File: rtl/result_skid_fifo.sv
// Small first-word-fall-through FIFO holding {row tag, row data} between SRAM and consumer.
module result_skid_fifo
    import tpu_drain_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ROW_W  = 5,
    parameter int unsigned DATA_W = 768
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              push,
    input  logic [ROW_W-1:0]                  push_row,
    input  logic [DATA_W-1:0]                 push_data,
    input  logic                              pop,
    output logic [clog2_min1(DEPTH+1)-1:0]    count,
    output logic [ROW_W-1:0]                  head_row,
    output logic [DATA_W-1:0]                 head_data
);

    localparam int unsigned PTR_W    = clog2_min1(DEPTH);
    localparam int unsigned CNT_BITS = clog2_min1(DEPTH + 1);

    logic [ROW_W-1:0]  row_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                row_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                row_mem[wr_ptr]  <= push_row;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            // simultaneous push and pop leave the occupancy unchanged
            case ({push, pop})
                2'b10:   count <= count + CNT_BITS'(1);
                2'b01:   count <= count - CNT_BITS'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_row  = row_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/tpu_result_drain.sv
// Walks the TOP_tpu result SRAM on each end_ rising edge and streams rows out on valid/ready.
module tpu_result_drain
    import tpu_drain_pkg::*;
#(
    parameter int unsigned ADDRESSSIZE     = 10,
    parameter int unsigned MATRIX_SIZE     = 32,
    parameter int unsigned PARTIAL_SUM_BW  = 24,
    parameter int unsigned WORDSIZE_Result = MATRIX_SIZE * PARTIAL_SUM_BW,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int unsigned SKID_DEPTH      = 2
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 end_,
    output logic                                 sram_result_re,
    output logic [ADDRESSSIZE-1:0]               sram_result_address,
    input  logic [WORDSIZE_Result-1:0]           sram_result_data_out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WORDSIZE_Result-1:0]           out_data,
    output logic [clog2_min1(MATRIX_SIZE)-1:0]   out_row,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err_overrun
);

    localparam int unsigned ROW_BITS = clog2_min1(MATRIX_SIZE);
    localparam int unsigned CNT_BITS = clog2_min1(SKID_DEPTH + 1);
    localparam int unsigned CR_W     = CNT_BITS + 1;
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(MATRIX_SIZE - 1);

    drain_state_e          state_q;
    drain_state_e          state_d;
    logic                  end_d;
    logic                  start_evt;
    logic [ROW_BITS-1:0]   rd_cnt;
    logic [ROW_BITS-1:0]   rd_row_q;
    logic                  inflight;
    logic                  pop;
    logic [CNT_BITS-1:0]   fifo_count;
    logic [CR_W-1:0]       credit;
    logic                  re_c;

    assign start_evt = end_ && !end_d;
    assign pop       = out_valid && out_ready;
    // rows held or in flight after this cycle's pop; must stay below the FIFO depth
    assign credit    = CR_W'(fifo_count) + CR_W'(inflight) - CR_W'(pop);

    always_comb begin
        state_d = state_q;
        re_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_evt) state_d = READ;
            end
            READ: begin
                if (credit < CR_W'(SKID_DEPTH)) begin
                    re_c = 1'b1;
                    if (rd_cnt == LAST_ROW) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_row == LAST_ROW) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            end_d       <= 1'b0;
            rd_cnt      <= '0;
            rd_row_q    <= '0;
            inflight    <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state_q  <= state_d;
            end_d    <= end_;
            inflight <= re_c;
            if (re_c) rd_row_q <= rd_cnt;
            if (state_q == IDLE && start_evt) begin
                rd_cnt <= '0;
            end else if (re_c) begin
                rd_cnt <= (rd_cnt == LAST_ROW) ? '0 : rd_cnt + ROW_BITS'(1);
            end
            // an accepted start clears the flag; a start during a drain sets it
            if (start_evt && state_q == IDLE) begin
                err_overrun <= 1'b0;
            end else if (start_evt && (state_q == READ || state_q == DRAIN)) begin
                err_overrun <= 1'b1;
            end
        end
    end

    result_skid_fifo #(
        .DEPTH  (SKID_DEPTH),
        .ROW_W  (ROW_BITS),
        .DATA_W (WORDSIZE_Result)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (inflight),
        .push_row  (rd_row_q),
        .push_data (sram_result_data_out),
        .pop       (pop),
        .count     (fifo_count),
        .head_row  (out_row),
        .head_data (out_data)
    );

    assign sram_result_re      = re_c;
    assign sram_result_address = ADDRESSSIZE'(BASE_ADDR + 32'(rd_cnt));
    assign out_valid           = (fifo_count != '0);
    assign out_last            = out_valid && (out_row == LAST_ROW);
    assign busy                = (state_q == READ) || (state_q == DRAIN);
    assign done                = (state_q == DONE);

endmodule

// File: tb/tb_tpu_result_drain.sv
// Randomized directed bench for tpu_result_drain against a row-sequence reference model.
module tb_tpu_result_drain;

    localparam int MS   = 32;
    localparam int W    = MS * 24;
    localparam int BASE = 992;

    logic          clk = 1'b0;
    logic          rstn;
    logic          end_;
    logic          sram_result_re;
    logic [9:0]    addr;
    logic [W-1:0]  sram_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [4:0]    out_row;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err_overrun;

    tpu_result_drain #(
        .ADDRESSSIZE    (10),
        .MATRIX_SIZE    (MS),
        .PARTIAL_SUM_BW (24),
        .BASE_ADDR      (BASE),
        .SKID_DEPTH     (2)
    ) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .end_                 (end_),
        .sram_result_re       (sram_result_re),
        .sram_result_address  (addr),
        .sram_result_data_out (sram_data),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_data             (out_data),
        .out_row              (out_row),
        .out_last             (out_last),
        .busy                 (busy),
        .done                 (done),
        .err_overrun          (err_overrun)
    );

    always #5 clk = ~clk;

    logic [W-1:0] rowmem [MS];

    // synchronous result SRAM: data one cycle after re
    always @(posedge clk) begin
        if (sram_result_re) sram_data <= rowmem[5'(addr - 10'(BASE))];
    end

    int n_cmp = 0;
    int n_bad = 0;

    int exp_row, reads, n_done, step_i, rdy_mode;
    int first_re, first_valid, last_step, done_step;
    bit done_next, prev_stall;
    logic [W-1:0] prev_data;
    logic [4:0]   prev_row;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_pattern();
        for (int i = 0; i < MS; i++) rowmem[i] = {MS{24'(i + 1)}};
    endtask

    task automatic fill_random();
        for (int i = 0; i < MS; i++)
            for (int j = 0; j < W / 32; j++) rowmem[i][j*32 +: 32] = $urandom;
    endtask

    // one clock: sample at negedge, then drive inputs 1 time unit after posedge
    task automatic step();
        bit pop;
        bit ok;
        @(negedge clk);
        pop = out_valid && out_ready;
        if (sram_result_re) begin
            chk("rd_addr", W'(addr), W'(BASE + reads));
            ok = (reads - exp_row - (pop ? 1 : 0)) < 2;
            chk("rd_credit", W'(ok), W'(1'b1));
            if (first_re < 0) first_re = step_i;
            reads++;
        end
        if (out_valid) begin
            chk("out_row", W'(out_row), W'(exp_row));
            chk("out_data", out_data, (exp_row < MS) ? rowmem[exp_row] : '0);
            chk("out_last", W'(out_last), W'(exp_row == MS - 1));
            if (first_valid < 0) first_valid = step_i;
        end
        if (prev_stall) begin
            chk("stall_data", out_data, prev_data);
            chk("stall_row", W'(out_row), W'(prev_row));
        end
        chk("done", W'(done), W'(done_next));
        if (done) begin
            n_done++;
            done_step = step_i;
        end
        done_next = pop && (exp_row == MS - 1);
        if (pop) begin
            if (exp_row == MS - 1) last_step = step_i;
            exp_row++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_row   = out_row;
        @(posedge clk);
        #1;
        step_i++;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (step_i % 4 == 0) || (step_i % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic start_drain();
        exp_row     = 0;
        reads       = 0;
        n_done      = 0;
        done_next   = 1'b0;
        prev_stall  = 1'b0;
        first_re    = -1;
        first_valid = -1;
        last_step   = -1;
        done_step   = -1;
        step_i      = 0;
        end_        = 1'b1;
        step();
    endtask

    task automatic run(input int max_steps, input int stop_row, input bit ovr);
        bit fired = 1'b0;
        int k = 0;
        while (n_done == 0 && exp_row != stop_row && k < max_steps) begin
            step();
            k++;
            end_ = 1'b0;
            if (ovr && !fired && exp_row == 10) begin
                end_  = 1'b1;
                fired = 1'b1;
            end
        end
        if (stop_row < 0) chk("drain_finished", W'(n_done), W'(1));
        else              chk("reached_row", W'(exp_row), W'(stop_row));
    endtask

    initial begin
        rstn      = 1'b0;
        end_      = 1'b0;
        out_ready = 1'b0;
        rdy_mode  = 0;
        done_next = 1'b0;
        fill_pattern();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", W'(out_valid), '0);
        chk("rst_data", out_data, '0);
        chk("rst_row", W'(out_row), '0);
        chk("rst_last", W'(out_last), '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_err", W'(err_overrun), '0);
        chk("rst_re", W'(sram_result_re), '0);
        chk("rst_addr", W'(addr), W'(BASE));
        @(posedge clk);
        #1;
        rstn      = 1'b1;
        out_ready = 1'b1;
        repeat (2) step();

        // basic drain with the counting pattern and ready held high
        rdy_mode = 0;
        start_drain();
        run(200, -1, 1'b0);
        repeat (3) step();
        chk("basic_first_re", W'(first_re), W'(1));
        chk("basic_first_valid", W'(first_valid), W'(3));
        chk("basic_last_step", W'(last_step), W'(3 + MS - 1));
        chk("basic_done_step", W'(done_step), W'(3 + MS));
        chk("basic_reads", W'(reads), W'(MS));
        chk("basic_rows", W'(exp_row), W'(MS));
        chk("basic_done_cnt", W'(n_done), W'(1));

        // backpressure with ready pattern 1,0,0,1
        fill_random();
        rdy_mode = 1;
        start_drain();
        run(400, -1, 1'b0);
        repeat (3) step();
        chk("bp_rows", W'(exp_row), W'(MS));
        chk("bp_reads", W'(reads), W'(MS));
        chk("bp_done_cnt", W'(n_done), W'(1));

        // overrun: second edge at row 10
        fill_random();
        rdy_mode = 0;
        start_drain();
        run(400, -1, 1'b1);
        repeat (3) step();
        chk("ovr_rows", W'(exp_row), W'(MS));
        chk("ovr_done_cnt", W'(n_done), W'(1));
        chk("ovr_err_set", W'(err_overrun), W'(1));
        fill_random();
        rdy_mode = 2;
        start_drain();
        chk("ovr_err_clear", W'(err_overrun), '0);
        run(400, -1, 1'b0);
        repeat (3) step();
        chk("ovr_next_rows", W'(exp_row), W'(MS));
        chk("ovr_err_stays", W'(err_overrun), '0);

        // reset mid-drain at row 15
        rdy_mode = 0;
        start_drain();
        run(400, 15, 1'b0);
        rstn = 1'b0;
        #1;
        chk("mrst_valid", W'(out_valid), '0);
        chk("mrst_busy", W'(busy), '0);
        chk("mrst_done", W'(done), '0);
        done_next  = 1'b0;
        prev_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mrst_hold_done", W'(done), '0);
            chk("mrst_hold_busy", W'(busy), '0);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        fill_random();
        rdy_mode = 2;
        start_drain();
        run(400, -1, 1'b0);
        repeat (3) step();
        chk("mrst_next_first_valid", W'(first_valid), W'(3));
        chk("mrst_next_rows", W'(exp_row), W'(MS));

        // end_ held high for 100 cycles
        fill_random();
        rdy_mode = 0;
        start_drain();
        for (int i = 0; i < 100; i++) step();
        end_ = 1'b0;
        repeat (5) step();
        chk("held_done_cnt", W'(n_done), W'(1));
        chk("held_rows", W'(exp_row), W'(MS));
        chk("held_reads", W'(reads), W'(MS));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
